// File: rtl/reg_pkg.sv
// +----------------------------------------------------------------------------+
// | reg_pkg : shared widths, typedefs and helpers for the operand-read stage   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package reg_pkg;

    localparam int c_REG_DATA_WIDTH = 16;
    localparam int c_REG_NUM_WIDTH  = 4;
    localparam int c_NUM_REGISTERS  = 16;

    typedef logic [c_REG_NUM_WIDTH-1:0]  reg_num_t;
    typedef logic [c_REG_DATA_WIDTH-1:0] reg_data_t;

    function automatic logic in_range(input logic [31:0] rn, input int num_regs);
        return rn < 32'(num_regs);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// +----------------------------------------------------------------------------+
// | reg_scoreboard : pending-destination tracking and per-port hazard detect   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_scoreboard #(
    parameter int REG_NUM_WIDTH  = 4,
    parameter int NUM_REGISTERS  = 16,
    parameter int NUM_READ_PORTS = 2,
    parameter int R0_ZERO        = 1,
    parameter int BYPASS         = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_set_en,
    input  logic [REG_NUM_WIDTH-1:0]              i_set_rn,
    input  logic                                  i_clr_en,
    input  logic [REG_NUM_WIDTH-1:0]              i_clr_rn,
    input  logic [NUM_READ_PORTS*REG_NUM_WIDTH-1:0] i_rd_rn,
    input  logic [NUM_READ_PORTS-1:0]             i_rd_use,
    output logic [NUM_READ_PORTS-1:0]             o_hazard
);

    logic [NUM_REGISTERS-1:0] r_pending;

    // A new producer claiming the register outranks the retiring writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                if (i_set_en && i_set_rn == REG_NUM_WIDTH'(i)) begin
                    r_pending[i] <= 1'b1;
                end else if (i_clr_en && i_clr_rn == REG_NUM_WIDTH'(i)) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        logic [REG_NUM_WIDTH-1:0] w_rn;
        logic                     w_pend;

        assign w_rn = i_rd_rn[p*REG_NUM_WIDTH +: REG_NUM_WIDTH];

        always_comb begin
            w_pend = 1'b0;
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                if (w_rn == REG_NUM_WIDTH'(i)) begin
                    w_pend = r_pending[i];
                end
            end
        end

        assign o_hazard[p] = i_rd_use[p] && w_pend
                           && !((R0_ZERO != 0) && (w_rn == '0))
                           && !((BYPASS != 0) && i_clr_en && (i_clr_rn == w_rn));
    end

endmodule

`default_nettype wire

// File: rtl/reg_read_stage.sv
// +----------------------------------------------------------------------------+
// | reg_read_stage : register file, operand read with writeback forwarding,    |
// | load-use scoreboard and registered valid/ready output stage.               |
// | Optional feature macro: REG_PORT_BYPASS_EN (same-cycle writeback bypass).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_read_stage
    import reg_pkg::*;
#(
    parameter int REG_DATA_WIDTH = c_REG_DATA_WIDTH,
    parameter int REG_NUM_WIDTH  = c_REG_NUM_WIDTH,
    parameter int NUM_REGISTERS  = c_NUM_REGISTERS,
    parameter int NUM_READ_PORTS = 2,
    parameter int R0_ZERO        = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [NUM_READ_PORTS*REG_NUM_WIDTH-1:0]  in_rn,
    input  logic [NUM_READ_PORTS-1:0]                in_use,
    input  logic                                     in_dest_en,
    input  logic [REG_NUM_WIDTH-1:0]                 in_dest,
    input  logic                                     wr_en,
    input  logic [REG_NUM_WIDTH-1:0]                 wr_rn,
    input  logic [REG_DATA_WIDTH-1:0]                wr_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0] out_rd,
    output logic                                     out_exc,
    output logic                                     exception,
    input  logic                                     exc_clr
);

`ifdef REG_PORT_BYPASS_EN
    localparam int c_BYPASS = 1;
`else
    localparam int c_BYPASS = 0;
`endif

    logic [REG_DATA_WIDTH-1:0]                 r_file [NUM_REGISTERS];
    logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0]  w_rd_data;
    logic [NUM_READ_PORTS-1:0]                 w_port_exc;
    logic [NUM_READ_PORTS-1:0]                 w_hazard;
    logic                                      w_dest_exc;
    logic                                      w_exc;
    logic                                      w_accept;
    logic                                      w_set_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                r_file[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                if (wr_en && wr_rn == REG_NUM_WIDTH'(i) && !((R0_ZERO != 0) && i == 0)) begin
                    r_file[i] <= wr_data;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
        logic [REG_NUM_WIDTH-1:0]  w_rn;
        logic [REG_DATA_WIDTH-1:0] w_data;

        assign w_rn = in_rn[p*REG_NUM_WIDTH +: REG_NUM_WIDTH];
        assign w_port_exc[p] = in_use[p] && !in_range(32'(w_rn), NUM_REGISTERS);
        assign w_rd_data[p*REG_DATA_WIDTH +: REG_DATA_WIDTH] = w_data;

        // Out-of-range numbers match no file entry and so read as zero.
        always_comb begin
            w_data = '0;
            if (w_port_exc[p] || ((R0_ZERO != 0) && w_rn == '0)) begin
                w_data = '0;
            end else if ((c_BYPASS != 0) && wr_en && wr_rn == w_rn) begin
                w_data = wr_data;
            end else begin
                for (int i = 0; i < NUM_REGISTERS; i++) begin
                    if (w_rn == REG_NUM_WIDTH'(i)) begin
                        w_data = r_file[i];
                    end
                end
            end
        end
    end

    assign w_dest_exc = in_dest_en && !in_range(32'(in_dest), NUM_REGISTERS);
    assign w_exc      = (|w_port_exc) || w_dest_exc;
    assign in_ready   = !(|w_hazard) && (!out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_set_en   = w_accept && in_dest_en && !w_exc
                      && !((R0_ZERO != 0) && in_dest == '0);

    reg_scoreboard #(
        .REG_NUM_WIDTH  (REG_NUM_WIDTH),
        .NUM_REGISTERS  (NUM_REGISTERS),
        .NUM_READ_PORTS (NUM_READ_PORTS),
        .R0_ZERO        (R0_ZERO),
        .BYPASS         (c_BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_set_en (w_set_en),
        .i_set_rn (in_dest),
        .i_clr_en (wr_en),
        .i_clr_rn (wr_rn),
        .i_rd_rn  (in_rn),
        .i_rd_use (in_use),
        .o_hazard (w_hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_exc   <= 1'b0;
            exception <= 1'b0;
        end else begin
            if (w_accept) begin
                out_valid <= 1'b1;
                out_rd    <= w_rd_data;
                out_exc   <= w_exc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_accept && w_exc) begin
                exception <= 1'b1;
            end else if (exc_clr) begin
                exception <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_read_stage.sv
// +----------------------------------------------------------------------------+
// | tb_reg_read_stage : directed self-checking bench for reg_read_stage        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reg_read_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_rn;
    logic [1:0]  in_use;
    logic        in_dest_en;
    logic [3:0]  in_dest;
    logic        wr_en;
    logic [3:0]  wr_rn;
    logic [15:0] wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd;
    logic        out_exc;
    logic        exception;
    logic        exc_clr;

    int n_checks = 0;
    int n_fail   = 0;

    reg_read_stage #(
        .REG_DATA_WIDTH (16),
        .REG_NUM_WIDTH  (4),
        .NUM_REGISTERS  (12),
        .NUM_READ_PORTS (2),
        .R0_ZERO        (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rn      (in_rn),
        .in_use     (in_use),
        .in_dest_en (in_dest_en),
        .in_dest    (in_dest),
        .wr_en      (wr_en),
        .wr_rn      (wr_rn),
        .wr_data    (wr_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_exc    (out_exc),
        .exception  (exception),
        .exc_clr    (exc_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] rn1, input logic [3:0] rn0, input logic [1:0] use_v,
                         input logic dest_en, input logic [3:0] dest);
        in_valid   = 1'b1;
        in_rn      = {rn1, rn0};
        in_use     = use_v;
        in_dest_en = dest_en;
        in_dest    = dest;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_use     = 2'b00;
        in_dest_en = 1'b0;
        in_rn      = '0;
        in_dest    = '0;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; exc_clr = 1'b0;
        wr_en = 1'b0; wr_rn = '0; wr_data = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_rd", out_rd, 32'h0);
        check("reset_out_exc", 32'(out_exc), 32'd0);
        check("reset_exception", 32'(exception), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Basic write then read, r0 ignores writes
        wr_en = 1'b1; wr_rn = 4'd3; wr_data = 16'h1234;
        tick();
        wr_rn = 4'd0; wr_data = 16'hFFFF;
        tick();
        wr_en = 1'b0;
        issue(4'd0, 4'd3, 2'b11, 1'b0, 4'd0);
        tick();
        idle();
        check("basic_out_valid", 32'(out_valid), 32'd1);
        check("basic_out_rd", out_rd, 32'h0000_1234);
        check("basic_out_exc", 32'(out_exc), 32'd0);
        tick();
        check("basic_consumed", 32'(out_valid), 32'd0);

        // Load-use hazard on r5
        issue(4'd0, 4'd0, 2'b00, 1'b1, 4'd5);
        tick();
        issue(4'd0, 4'd5, 2'b01, 1'b0, 4'd0);
        #1;
        check("hazard_stall_0", 32'(in_ready), 32'd0);
        tick();
        check("hazard_stall_1", 32'(in_ready), 32'd0);
        wr_en = 1'b1; wr_rn = 4'd5; wr_data = 16'hBEEF;
        #1;
`ifdef REG_PORT_BYPASS_EN
        check("hazard_wb_cycle_ready", 32'(in_ready), 32'd1);
        tick();
        wr_en = 1'b0;
        idle();
`else
        check("hazard_wb_cycle_ready", 32'(in_ready), 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        check("hazard_after_wb_ready", 32'(in_ready), 32'd1);
        tick();
        idle();
`endif
        check("hazard_out_valid", 32'(out_valid), 32'd1);
        check("hazard_out_rd", out_rd, 32'h0000_BEEF);
        tick();

        // Backpressure: A held three cycles while B waits
        out_ready = 1'b0;
        issue(4'd0, 4'd3, 2'b01, 1'b0, 4'd0);
        tick();
        issue(4'd0, 4'd5, 2'b01, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_rd", out_rd, 32'h0000_1234);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_b_out_rd", out_rd, 32'h0000_BEEF);
        issue(4'd3, 4'd5, 2'b11, 1'b0, 4'd0);
        tick();
        idle();
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_out_rd", out_rd, 32'h1234_BEEF);
        tick();
        check("b2b_drained", 32'(out_valid), 32'd0);

        // Range errors (NUM_REGISTERS = 12)
        issue(4'd0, 4'd13, 2'b01, 1'b0, 4'd0);
        tick();
        check("range_out_exc", 32'(out_exc), 32'd1);
        check("range_port_data", out_rd, 32'h0);
        check("range_exception", 32'(exception), 32'd1);
        issue(4'd13, 4'd3, 2'b01, 1'b0, 4'd0);
        tick();
        check("unused_port_exc", 32'(out_exc), 32'd0);
        check("unused_port_data", out_rd[15:0], 32'h1234);
        check("exception_sticky", 32'(exception), 32'd1);
        idle();
        exc_clr = 1'b1;
        tick();
        exc_clr = 1'b0;
        check("exception_cleared", 32'(exception), 32'd0);
        issue(4'd0, 4'd0, 2'b00, 1'b1, 4'd14);
        tick();
        idle();
        check("dest_range_exc", 32'(out_exc), 32'd1);
        exc_clr = 1'b1;
        tick();
        exc_clr = 1'b0;

        // Same-edge pending set and clear of r7
        wr_en = 1'b1; wr_rn = 4'd7; wr_data = 16'h7777;
        issue(4'd0, 4'd0, 2'b00, 1'b1, 4'd7);
        tick();
        wr_en = 1'b0;
        issue(4'd0, 4'd7, 2'b01, 1'b0, 4'd0);
        #1;
        check("set_wins_stall_0", 32'(in_ready), 32'd0);
        tick();
        check("set_wins_stall_1", 32'(in_ready), 32'd0);

        // Reset mid-operation with held packet and pending r7
        out_ready = 1'b0;
        issue(4'd0, 4'd3, 2'b01, 1'b1, 4'd9);
        tick();
        idle();
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_rd", out_rd, 32'h0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(4'd7, 4'd3, 2'b11, 1'b0, 4'd0);
        #1;
        check("post_reset_no_pending", 32'(in_ready), 32'd1);
        tick();
        idle();
        check("post_reset_file_clear", out_rd, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_read_stage.md
# reg_read_stage

Parametrised operand-read stage for the CSC142 pipeline, sitting between decode and execute. It owns the register file, supplies NUM_READ_PORTS source operands per instruction with automatic writeback forwarding, and tracks pending destination writes in a scoreboard so load-use hazards stall decode. Results are registered into a valid/ready output stage feeding execute.

## Interface
- REG_DATA_WIDTH, 16, operand width
- REG_NUM_WIDTH, 4, register-number width
- NUM_REGISTERS, 16, implemented registers, at most 2^REG_NUM_WIDTH
- NUM_READ_PORTS, 2, source operands per instruction
- R0_ZERO, 1, 1: register 0 reads as zero and ignores writes
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_rn  in  NUM_READ_PORTS*REG_NUM_WIDTH  source register numbers, port p at [p*W +: W]
- in_use  in  NUM_READ_PORTS  per-port "source used" (unused ports never stall or except)
- in_dest_en, in_dest  in  1, REG_NUM_WIDTH  instruction will write in_dest later
- wr_en, wr_rn, wr_data  in  1, REG_NUM_WIDTH, REG_DATA_WIDTH  writeback port
- out_valid  out  1  operands held for execute
- out_ready  in  1  execute consumes
- out_rd  out  NUM_READ_PORTS*REG_DATA_WIDTH  operand data, same packing
- out_exc  out  1  held instruction had an out-of-range register number
- exception  out  1  sticky OR of every out_exc issued
- exc_clr  in  1  clears exception

## Operation
- Read per used port: bypass data if wr_en and wr_rn==rn (REG_PORT_BYPASS_EN), else file data; R0_ZERO and rn==0 give 0.
- Scoreboard pending[NUM_REGISTERS]: set at acceptance when in_dest_en; cleared on wr_en to that register.
- Port hazard: in_use[p] and pending[rn_p] and not (bypass active and wr_en and wr_rn==rn_p). Register 0 never hazards when R0_ZERO.
- stall = any port hazard; in_ready = !stall and (!out_valid or out_ready).
- Range check: used rn >= NUM_REGISTERS, or in_dest_en with in_dest >= NUM_REGISTERS, sets out_exc with the packet; offending port data 0; no pending bit set; never stalls.
- Writeback to a non-pending register: written normally, no error. Writes with wr_rn >= NUM_REGISTERS ignored.
- Pending set and clear of the same register same edge: set wins (new producer).
- exception: set when out_exc is loaded 1; exc_clr clears; simultaneous set and clear: set wins.

## Timing
- Reset: file all 0, pending all 0, out_valid 0, out_rd 0, out_exc 0, exception 0; in_ready 1 right after reset deassertion.
- Acceptance (in_valid && in_ready) at edge N: out_rd/out_exc/out_valid valid after edge N; one-cycle latency.
- out_valid && !out_ready: outputs held stable; in_ready 0.
- Back-to-back: accept every cycle while out_ready is 1 and no hazard.
- File write at edge on wr_en; read sees it from the next cycle, or same cycle via bypass.
- Reset mid-operation clears held packet and scoreboard; in-flight producers are the pipeline's responsibility.

## Configuration
- REG_PORT_BYPASS_EN defined: same-cycle writeback forwarded to read ports; a hazard resolved by the current writeback does not stall.
- Undefined: no bypass; a hazarded read stalls until the cycle after writeback, then reads the file (one extra stall cycle per load-use).

## Structure
- Package reg_pkg: REG_DATA_WIDTH, REG_NUM_WIDTH, NUM_REGISTERS defaults, register-number and data typedefs.
- Sub-module reg_scoreboard: pending vector, set/clear priority, per-port hazard outputs; instantiated once.
- Register file, bypass muxes, output stage in top.

## Test plan
- Reset, write r3=0x1234, read rn={3,0} next cycle -> out_rd={0x1234,0x0000}, out_valid 1 one cycle after acceptance.
- Issue dest r5, then read r5: in_ready 0 until wr_en r5=0xBEEF; with bypass accepted that cycle, without bypass next cycle; out_rd=0xBEEF.
- out_ready held 0 three cycles with new in_valid -> out_rd stable, in_ready 0, no packet lost or duplicated.
- NUM_REGISTERS=12, read rn=13 -> out_exc 1, port data 0, exception sticky until exc_clr; unused-port rn=13 -> no exception.
- Same-edge wr_en r7 and issue dest r7 -> pending[r7] remains 1, subsequent read of r7 stalls.
- Assert rst_n low with out_valid and pending set -> all outputs 0 immediately, pending cleared.
